// File: rtl/moving_average.sv
// moving_average: running sum of the last SNAPSHOT_COUNT accepted samples.
// The output is the window sum (average times SNAPSHOT_COUNT), so no precision is lost.
module moving_average #(
  parameter int SNAPSHOT_COUNT  = 8,
  parameter int WORD_LENGTH_IN  = 80,
  parameter int WORD_LENGTH_OUT = 88
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [WORD_LENGTH_IN-1:0]  s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic signed [WORD_LENGTH_OUT-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
);
  localparam int PW = $clog2(SNAPSHOT_COUNT);
  logic signed [WORD_LENGTH_IN-1:0] buffer [SNAPSHOT_COUNT];
  logic [PW-1:0] ptr;
  logic signed [WORD_LENGTH_OUT-1:0] sum, sum_next, new_ext, old_ext;
  logic unused_tready;
  assign unused_tready = m_axis_tready;
  assign s_axis_tready = 1'b1;
  assign new_ext = WORD_LENGTH_OUT'(s_axis_tdata);
  assign old_ext = WORD_LENGTH_OUT'(buffer[ptr]);
  // Incremental update: add the newest sample, drop the one it overwrites.
  assign sum_next = sum + new_ext - old_ext;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SNAPSHOT_COUNT; i++) buffer[i] <= '0;
      ptr <= '0;
      sum <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        buffer[ptr] <= s_axis_tdata;
        ptr <= ptr + PW'(1);
        sum <= sum_next;
        m_axis_tdata <= sum_next;
      end
    end
  end
endmodule

// File: tb/tb_moving_average.sv
// tb_moving_average: directed and random stimulus checked against a queue-based window-sum model.
module tb_moving_average;
  logic clk = 0, rst = 1;
  logic signed [79:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 0, m_axis_tready = 1;
  logic s_axis_tready, m_axis_tvalid;
  logic signed [87:0] m_axis_tdata;
  int tests = 0, fails = 0;
  logic signed [79:0] q[$];
  logic signed [87:0] last = '0;
  logic signed [79:0] pmax, nmax;

  moving_average dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic signed [79:0] d, input logic r);
    logic signed [87:0] s;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata = d;
    m_axis_tready = r;
    @(posedge clk);
    #1;
    if (v) begin
      q.push_back(d);
      if (q.size() > 8) void'(q.pop_front());
      s = '0;
      foreach (q[i]) s += 88'(q[i]);
      last = s;
    end
    chk("tvalid", {87'd0, m_axis_tvalid}, {87'd0, v});
    chk("tdata", m_axis_tdata, last);
    chk("tready", {87'd0, s_axis_tready}, 88'd1);
  endtask

  function automatic logic signed [79:0] rnd80();
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return r[79:0];
  endfunction

  initial begin
    #1 rst = 0;
    #1;
    chk("rst_tvalid", {87'd0, m_axis_tvalid}, 88'd0);
    chk("rst_tdata", m_axis_tdata, 88'd0);
    chk("rst_tready", {87'd0, s_axis_tready}, 88'd1);
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) step(1, 80'sd5, 1);
    chk("const5_final", m_axis_tdata, 88'sd40);
    for (int i = 0; i < 8; i++) step(1, 80'sd0, 1);
    step(1, 80'sd100, 1);
    for (int i = 0; i < 9; i++) step(1, 80'sd0, 1);
    chk("impulse_gone", m_axis_tdata, 88'sd0);
    for (int i = 0; i < 8; i++) step(1, -80'sd3, 1);
    chk("neg3_final", m_axis_tdata, -88'sd24);
    for (int i = 0; i < 8; i++) step(1, (i % 2) ? -80'sd7 : 80'sd7, 1);
    chk("alt7_final", m_axis_tdata, 88'sd0);
    for (int i = 0; i < 8; i++) step(1, 80'sd0, 1);
    step(1, 80'sd4, 1);
    step(0, rnd80(), 1);
    chk("gap_hold", m_axis_tdata, 88'sd4);
    step(0, rnd80(), 1);
    step(1, 80'sd6, 1);
    chk("gap_sum", m_axis_tdata, 88'sd10);
    pmax = {1'b0, {79{1'b1}}};
    nmax = {1'b1, 79'd0};
    for (int i = 0; i < 8; i++) step(1, pmax, 1);
    chk("full_pos", m_axis_tdata, ((88'sd1 <<< 79) - 88'sd1) * 88'sd8);
    for (int i = 0; i < 8; i++) step(1, nmax, 1);
    chk("full_neg", m_axis_tdata, -(88'sd1 <<< 82));
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 3) != 0), rnd80(), 1'($urandom));
    for (int i = 0; i < 5; i++) step(1, 80'sd9, 0);
    #2 rst = 0;
    #1;
    chk("mid_rst_tvalid", {87'd0, m_axis_tvalid}, 88'd0);
    chk("mid_rst_tdata", m_axis_tdata, 88'd0);
    chk("mid_rst_tready", {87'd0, s_axis_tready}, 88'd1);
    q.delete();
    last = '0;
    @(negedge clk);
    s_axis_tvalid = 0;
    m_axis_tready = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) step(1, 80'sd2, 0);
    chk("restart_final", m_axis_tdata, 88'sd16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
